// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types: FSM state enum, default widths, queue entry layout
package fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int QDEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  addr;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {addr,instr} with flush and occupancy count
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int AW    = ADDR_W_DEF,
    parameter int IW    = INSTR_W_DEF,
    parameter int DEPTH = QDEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [IW-1:0] push_instr,
    input  logic          pop,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [IW-1:0] head_instr,
    output logic [CW-1:0] count
);

    logic [AW-1:0] addr_mem  [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head outputs are masked to zero while empty.
    always_ff @(posedge clkin) begin
        if (do_push && !flush) begin
            addr_mem[wr_ptr]  <= push_addr;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_valid = (count != '0);
    assign head_addr  = head_valid ? addr_mem[rd_ptr]  : '0;
    assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch address FSM and memory handshake; optional FETCH_STALL_CNT_EN stall counter
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int QDEPTH  = QDEPTH_DEF,
    localparam int CW     = $clog2(QDEPTH) + 1
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ins_valid,
    output logic [INSTR_W-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_addr,
    input  logic               ins_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0]     q_count;
    logic              issue;
    logic              push;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                // Only one read in flight, so the queue count alone covers the reserved slot.
                if (!redir_valid && (q_count < CW'(QDEPTH))) begin
                    state_nxt = REQ;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                    push      = !redir_valid;
                end else if (redir_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            mem_addr   <= '0;
        end else begin
            state <= state_nxt;
            if (issue) mem_addr <= fetch_addr;
            if (redir_valid)  fetch_addr <= redir_addr;
            else if (push)    fetch_addr <= fetch_addr + ADDR_W'(1);
        end
    end

    assign mem_req = (state != IDLE);

    fetch_queue #(
        .AW    (ADDR_W),
        .IW    (INSTR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clkin      (clkin),
        .reset      (reset),
        .flush      (redir_valid),
        .push       (push),
        .push_addr  (mem_addr),
        .push_instr (mem_rdata),
        .pop        (ins_valid && ins_ready),
        .head_valid (ins_valid),
        .head_addr  (ins_addr),
        .head_instr (ins_data),
        .count      (q_count)
    );

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (ins_ready && !ins_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a fixed-latency memory model
module tb_instr_fetch;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        redir_valid = 1'b0;
    logic [7:0]  redir_addr = 8'h00;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [7:0]  ins_addr;
    logic        ins_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         age = 0;
    logic [7:0] exp_q[$];

    assign mem_ack   = model_ack | stray_ack;
    assign mem_rdata = {~mem_addr, mem_addr};

    instr_fetch dut (
        .clkin       (clkin),
        .reset       (reset),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_addr    (ins_addr),
        .ins_ready   (ins_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial forever #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory acks in the second cycle that mem_req is seen high.
    initial forever begin
        @(negedge clkin);
        if (model_ack) begin
            model_ack = 1'b0;
            age = 0;
        end else if (mem_req && !reset) begin
            age++;
            if (age >= 2) model_ack = 1'b1;
        end else begin
            age = 0;
        end
    end

    initial forever begin
        logic [7:0] e;
        @(negedge clkin);
        if (!reset && ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_instr: got addr %0h expected none", ins_addr);
            end else begin
                e = exp_q.pop_front();
                chk("ins_addr", 32'(ins_addr), 32'(e));
                chk("ins_data", 32'(ins_data), 32'({~e, e}));
            end
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clkin); #1;
        reset = 1'b1;
        redir_valid = 1'b0;
        ins_ready = rdy;
        exp_q.delete();
        repeat (2) begin @(posedge clkin); #1; end
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clkin); #1;
            t++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        ins_ready = 1'b0;
    endtask

    task automatic wait_req(input logic [7:0] a, input string name);
        int t = 0;
        while (!(mem_req && mem_addr == a) && t < 200) begin
            @(posedge clkin); #1;
            t++;
        end
        chk(name, {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, a});
    endtask

    task automatic push_exp(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
    endtask

    initial begin
        int t;
        #2;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_ins_valid", 32'(ins_valid), 0);
        chk("rst_ins_addr", 32'(ins_addr), 0);
        chk("rst_ins_data", 32'(ins_data), 0);

        // Straight-line fetch from address 0
        do_reset(1'b1);
        push_exp(8'h00, 6);
        wait_drain("t1_drain");

        // Backpressure: queue fills with 0..3, then no further request
        do_reset(1'b0);
        repeat (30) begin @(posedge clkin); #1; end
        chk("t2_full_no_req", 32'(mem_req), 0);
        chk("t2_head_valid", 32'(ins_valid), 1);
        chk("t2_head_addr", 32'(ins_addr), 0);
        push_exp(8'h00, 6);
        ins_ready = 1'b1;
        wait_drain("t2_drain");

        // Redirect while the read for 0x05 is outstanding
        do_reset(1'b1);
        push_exp(8'h00, 5);
        wait_req(8'h05, "t3_req5");
        redir_valid = 1'b1;
        redir_addr = 8'h40;
        push_exp(8'h40, 4);
        @(posedge clkin); #1;
        redir_valid = 1'b0;
        chk("t3_discard_hold", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h05});
        t = 0;
        while (!(mem_req && mem_addr != 8'h05) && t < 50) begin
            @(posedge clkin); #1;
            t++;
        end
        chk("t3_redir_req", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h40});
        wait_drain("t3_drain");

        // Address wrap after redirect to 0xFE
        do_reset(1'b1);
        redir_valid = 1'b1;
        redir_addr = 8'hFE;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        @(posedge clkin); #1;
        redir_valid = 1'b0;
        wait_drain("t4_drain");

        // Reset with a read in flight and 3 queued entries; stray ack afterwards
        do_reset(1'b0);
        wait_req(8'h03, "t5_req3");
        chk("t5_pre_valid", 32'(ins_valid), 1);
        reset = 1'b1;
        #1;
        chk("t5_mem_req", 32'(mem_req), 0);
        chk("t5_mem_addr", 32'(mem_addr), 0);
        chk("t5_ins_valid", 32'(ins_valid), 0);
        chk("t5_ins_addr", 32'(ins_addr), 0);
        chk("t5_ins_data", 32'(ins_data), 0);
        stray_ack = 1'b1;
        @(posedge clkin); #1;
        reset = 1'b0;
        ins_ready = 1'b1;
        @(posedge clkin); #1;
        stray_ack = 1'b0;
        push_exp(8'h00, 3);
        wait_drain("t5_drain");

`ifdef FETCH_STALL_CNT_EN
        do_reset(1'b0);
        chk("t6_cnt_rst", 32'(stall_cnt), 0);
        redir_valid = 1'b1;
        ins_ready = 1'b1;
        repeat (5) begin @(posedge clkin); #1; end
        ins_ready = 1'b0;
        chk("t6_cnt5", 32'(stall_cnt), 5);
        @(posedge clkin); #1;
        chk("t6_cnt_hold", 32'(stall_cnt), 5);
        redir_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
